op_mem: RTL and testbench
=========================

Name: op_mem

Overview:
- Output-peripheral memory for the LSU store path; the write-side counterpart of the input-peripheral memory that samples switches and buttons.
- Holds LSU-written words for red LEDs, green LEDs, eight 7-segment digits and the LCD, and drives those pins from registered state.
- Supports byte-masked stores and registered read-back.
- Runs an LCD valid/ready handshake so the LCD controller consumes each LCD update exactly once.

Parameters:
- ADDR_BASE, 32'h0000_7000, base of the 64-byte output-peripheral window (must be 64-byte aligned)
- NUM_WORD, 16, words of backing storage, indexed by i_lsu_addr[5:2]

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-low; one clock domain only
- i_lsu_wren  in  1  store strobe, one word per cycle
- i_lsu_addr  in  32  byte address
- i_lsu_bmask  in  4  byte-lane enables; bit n enables lane n
- i_st_data  in  32  store data, lane-aligned
- i_lcd_rdy  in  1  LCD controller accepts o_io_lcd
- o_op_data  out  32  registered read-back of the addressed word
- o_io_ledr  out  17  word0 (0x7000) bits [16:0]
- o_io_ledg  out  8  word4 (0x7010) bits [7:0]
- o_io_hex0..o_io_hex7  out  7 each  digit n taken from byte (n mod 4) of word8 (0x7020, n<4) or word9 (0x7024, n>=4)
- o_io_lcd  out  32  word12 (0x7030)
- o_lcd_vld  out  1  pending LCD update

Behaviour:
- hit = (i_lsu_addr[31:6] == ADDR_BASE[31:6]); idx = i_lsu_addr[5:2]; i_lsu_addr[1:0] ignored.
- Store:
  - On rising edge with i_lsu_wren & hit, for each lane n with i_lsu_bmask[n]=1, mem[idx][8n+7:8n] <= i_st_data[8n+7:8n].
  - Masked lanes keep their value. Mask 4'b0000 causes no change.
- All 16 words are writable and readable. Only words 0, 4, 8, 9 and 12 drive pins.
- Read:
  - o_op_data <= hit ? mem[idx] : 32'h0, registered, latency 1 cycle.
  - A same-cycle store to the same word returns the OLD value. The new value is visible from the next read.
- Peripheral outputs are combinational from storage, so they change the cycle after the store edge. No glitch path from LSU inputs.
- LCD handshake, two-state FSM:
  - IDLE: o_lcd_vld=0. A store hitting word12 with any lane enabled -> PEND.
  - PEND: o_lcd_vld=1 and o_io_lcd is stable unless rewritten. i_lcd_rdy=1 -> IDLE.
  - Store to word12 in the same cycle as i_lcd_rdy in PEND: stay in PEND. The new value is a fresh update; the old value counts as consumed.
  - Store to word12 in PEND without rdy: value overwritten, stay in PEND, one transfer only.
  - i_lcd_rdy in IDLE is ignored.
- Reset (i_rst=0, asynchronous) mid-operation:
  - All mem words 0, o_op_data=0, FSM=IDLE, o_lcd_vld=0.
  - Hence o_io_ledr=0, o_io_ledg=0, o_io_lcd=0, and hex outputs as defined below.
  - A pending LCD update is dropped.
- Non-hit stores and reads never modify state.

Optional Feature:
- Macro OP_HEX_DECODE_EN.
- Defined:
  - Each hex digit output is the active-low 7-segment pattern of the low nibble of its byte, segment order {g,f,e,d,c,b,a}.
  - Byte bit 7 = 1 blanks the digit (7'h7F).
  - Reset value of every digit is 7'h40 (shows "0").
- Undefined:
  - Each digit output is the raw byte bits [6:0].
  - Reset value 7'h00.

Decomposition:
- Shared package op_mem_pkg holds:
  - ADDR_BASE default
  - word-index constants: WIDX_LEDR=0, WIDX_LEDG=4, WIDX_HEX_LO=8, WIDX_HEX_HI=9, WIDX_LCD=12
  - LCD FSM enum lcd_st_e {LCD_IDLE, LCD_PEND}
  - the 16-entry seven-segment pattern constant
- One sub-module, op_hex_dec: nibble plus blank in -> 7-bit segments out, combinational, instantiated 8 times under OP_HEX_DECODE_EN.

Test Plan:
- Reset, then store 0x0001_FFFF to 0x7000 with mask 1111 -> o_io_ledr=17'h1FFFF next cycle; read 0x7000 returns 0x0001_FFFF after 1 cycle.
- Store 0xAABBCCDD to 0x7010, then 0x11223344 with mask 0100 -> read-back 0xAA22CCDD; o_io_ledg=8'hDD.
- Store 0x03020100 to 0x7020 with decode on -> hex0..hex3 = 7'h40, 7'h79, 7'h24, 7'h30; with decode off -> 7'h00, 7'h01, 7'h02, 7'h03.
- LCD handshake:
  - Store 0x12345678 to 0x7030 with i_lcd_rdy=0 -> o_lcd_vld=1.
  - Store 0x9ABCDEF0 to 0x7030 -> o_io_lcd updates, still one pending transfer.
  - Raise rdy for 1 cycle -> o_lcd_vld=0.
- Store to 0x7030 in the same cycle i_lcd_rdy=1 while in PEND -> o_lcd_vld stays 1 holding the new value.
- Store 0xFFFFFFFF to 0x8000 -> no state change, read returns 0. Assert i_rst=0 asynchronously mid-PEND -> o_lcd_vld and all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/op_mem_pkg.sv
// Shared constants for the output-peripheral memory: window base, word indices,
// LCD handshake states and the active-low seven-segment table.
package op_mem_pkg;

   localparam logic [31:0] ADDR_BASE_DEF = 32'h0000_7000;
   localparam int unsigned NUM_WORD_DEF  = 16;

   localparam logic [3:0] WIDX_LEDR   = 4'd0;
   localparam logic [3:0] WIDX_LEDG   = 4'd4;
   localparam logic [3:0] WIDX_HEX_LO = 4'd8;
   localparam logic [3:0] WIDX_HEX_HI = 4'd9;
   localparam logic [3:0] WIDX_LCD    = 4'd12;

   typedef enum logic [0:0] {
      LCD_IDLE = 1'b0,
      LCD_PEND = 1'b1
   } lcd_st_e;

   // Segment order {g,f,e,d,c,b,a}, active low; entry 0 is the rightmost element.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/op_hex_dec.sv
// Nibble to active-low seven-segment decoder with blanking; purely combinational.
module op_hex_dec
   import op_mem_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   assign seg_o = blank_i ? 7'h7F : SEG_LUT[nib_i];

endmodule

// File: rtl/op_mem.sv
// Output-peripheral memory: byte-masked LSU stores, registered read-back, pin drive
// and LCD valid/ready handshake. Define OP_HEX_DECODE_EN for seven-segment decoding.
module op_mem
   import op_mem_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF,
   parameter int unsigned NUM_WORD  = NUM_WORD_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_lsu_wren,
   input  logic [31:0] i_lsu_addr,
   input  logic [3:0]  i_lsu_bmask,
   input  logic [31:0] i_st_data,
   input  logic        i_lcd_rdy,
   output logic [31:0] o_op_data,
   output logic [16:0] o_io_ledr,
   output logic [7:0]  o_io_ledg,
   output logic [6:0]  o_io_hex0,
   output logic [6:0]  o_io_hex1,
   output logic [6:0]  o_io_hex2,
   output logic [6:0]  o_io_hex3,
   output logic [6:0]  o_io_hex4,
   output logic [6:0]  o_io_hex5,
   output logic [6:0]  o_io_hex6,
   output logic [6:0]  o_io_hex7,
   output logic [31:0] o_io_lcd,
   output logic        o_lcd_vld
);

   localparam logic [25:0] BASE_HI = ADDR_BASE[31:6];

   logic [31:0] mem_q [NUM_WORD];
   logic [31:0] wr_word_d;
   logic [31:0] op_data_d;
   logic [31:0] op_data_q;
   lcd_st_e     lcd_st_q;
   lcd_st_e     lcd_st_d;
   logic        hit_s;
   logic        wr_hit_s;
   logic        lcd_wr_s;
   logic [3:0]  idx_s;
   logic [6:0]  hex_s [8];
   logic        unused_addr_s;

   assign hit_s         = (i_lsu_addr[31:6] == BASE_HI);
   assign idx_s         = i_lsu_addr[5:2];
   assign unused_addr_s = ^i_lsu_addr[1:0];
   assign wr_hit_s      = i_lsu_wren & hit_s & (|i_lsu_bmask);
   assign lcd_wr_s      = wr_hit_s & (idx_s == WIDX_LCD);

   // Merge enabled store lanes into the addressed word.
   always_comb begin
      wr_word_d = mem_q[idx_s];
      for (int n = 0; n < 4; n++) begin
         if (i_lsu_bmask[n]) begin
            wr_word_d[8*n +: 8] = i_st_data[8*n +: 8];
         end else begin
            wr_word_d[8*n +: 8] = mem_q[idx_s][8*n +: 8];
         end
      end
   end

   // Read-back samples storage before this edge's store lands, so it returns the old word.
   always_comb begin
      if (hit_s) begin
         op_data_d = mem_q[idx_s];
      end else begin
         op_data_d = 32'h0000_0000;
      end
   end

   // LCD handshake: a store to the LCD word always opens a fresh transfer.
   always_comb begin
      lcd_st_d = lcd_st_q;
      case (lcd_st_q)
         LCD_IDLE: begin
            if (lcd_wr_s) lcd_st_d = LCD_PEND;
            else          lcd_st_d = LCD_IDLE;
         end
         LCD_PEND: begin
            if (lcd_wr_s)       lcd_st_d = LCD_PEND;
            else if (i_lcd_rdy) lcd_st_d = LCD_IDLE;
            else                lcd_st_d = LCD_PEND;
         end
         default: lcd_st_d = LCD_IDLE;
      endcase
   end

   // Backing storage.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int w = 0; w < int'(NUM_WORD); w++) begin
            mem_q[w] <= 32'h0000_0000;
         end
      end else if (wr_hit_s) begin
         mem_q[idx_s] <= wr_word_d;
      end
   end

   // Read-back register and LCD state.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         op_data_q <= 32'h0000_0000;
         lcd_st_q  <= LCD_IDLE;
      end else begin
         op_data_q <= op_data_d;
         lcd_st_q  <= lcd_st_d;
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_hex
`ifdef OP_HEX_DECODE_EN
      op_hex_dec u_dec (
         .nib_i   (mem_q[(g < 4) ? WIDX_HEX_LO : WIDX_HEX_HI][8*(g%4) +: 4]),
         .blank_i (mem_q[(g < 4) ? WIDX_HEX_LO : WIDX_HEX_HI][8*(g%4) + 7]),
         .seg_o   (hex_s[g])
      );
`else
      assign hex_s[g] = mem_q[(g < 4) ? WIDX_HEX_LO : WIDX_HEX_HI][8*(g%4) +: 7];
`endif
   end

   assign o_op_data = op_data_q;
   assign o_io_ledr = mem_q[WIDX_LEDR][16:0];
   assign o_io_ledg = mem_q[WIDX_LEDG][7:0];
   assign o_io_lcd  = mem_q[WIDX_LCD];
   assign o_lcd_vld = (lcd_st_q == LCD_PEND);
   assign o_io_hex0 = hex_s[0];
   assign o_io_hex1 = hex_s[1];
   assign o_io_hex2 = hex_s[2];
   assign o_io_hex3 = hex_s[3];
   assign o_io_hex4 = hex_s[4];
   assign o_io_hex5 = hex_s[5];
   assign o_io_hex6 = hex_s[6];
   assign o_io_hex7 = hex_s[7];

endmodule

// File: tb/tb_op_mem.sv
// Self-checking bench for op_mem: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_op_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wren;
   logic [31:0] addr;
   logic [3:0]  bmask;
   logic [31:0] st_data;
   logic        rdy;
   wire  [31:0] op_data;
   wire  [16:0] ledr;
   wire  [7:0]  ledg;
   wire  [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   wire  [31:0] lcd;
   wire         lcd_vld;
   wire  [6:0]  hex_a [8];

   int total = 0;
   int bad   = 0;

   logic [31:0] mm [16];
   logic        pend;
   logic [31:0] exp_rd;

`ifdef OP_HEX_DECODE_EN
   localparam logic [6:0] HEX_RST = 7'h40;
`else
   localparam logic [6:0] HEX_RST = 7'h00;
`endif

   op_mem dut (
      .i_clk       (clk),
      .i_rst       (rst_n),
      .i_lsu_wren  (wren),
      .i_lsu_addr  (addr),
      .i_lsu_bmask (bmask),
      .i_st_data   (st_data),
      .i_lcd_rdy   (rdy),
      .o_op_data   (op_data),
      .o_io_ledr   (ledr),
      .o_io_ledg   (ledg),
      .o_io_hex0   (hex0),
      .o_io_hex1   (hex1),
      .o_io_hex2   (hex2),
      .o_io_hex3   (hex3),
      .o_io_hex4   (hex4),
      .o_io_hex5   (hex5),
      .o_io_hex6   (hex6),
      .o_io_hex7   (hex7),
      .o_io_lcd    (lcd),
      .o_lcd_vld   (lcd_vld)
   );

   assign hex_a[0] = hex0;
   assign hex_a[1] = hex1;
   assign hex_a[2] = hex2;
   assign hex_a[3] = hex3;
   assign hex_a[4] = hex4;
   assign hex_a[5] = hex5;
   assign hex_a[6] = hex6;
   assign hex_a[7] = hex7;

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [7:0] b);
      logic [6:0] s;
`ifdef OP_HEX_DECODE_EN
      case (b[3:0])
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      if (b[7]) s = 7'h7F;
`else
      s = b[6:0];
`endif
      return s;
   endfunction

   function automatic logic [6:0] exp_hex(input int n);
      logic [31:0] w;
      w = (n < 4) ? mm[8] : mm[9];
      return seg_of(w[8*(n%4) +: 8]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mm[i] = 32'h0;
      pend   = 1'b0;
      exp_rd = 32'h0;
   endtask

   // One bus cycle: drive, update the model, sample 1 time unit after the edge.
   task automatic step(input logic w, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic r);
      logic        hit;
      int          idx;
      logic [31:0] nxt_rd;
      wren = w; addr = a; bmask = m; st_data = d; rdy = r;
      hit    = (a >= 32'h0000_7000) && (a < 32'h0000_7040);
      idx    = int'(a[5:2]);
      nxt_rd = hit ? mm[idx] : 32'h0;
      if (w && hit) begin
         for (int n = 0; n < 4; n++) if (m[n]) mm[idx][8*n +: 8] = d[8*n +: 8];
      end
      if (w && hit && idx == 12 && m != 4'b0000) pend = 1'b1;
      else if (r) pend = 1'b0;
      @(posedge clk);
      #1;
      exp_rd = nxt_rd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wren = 1'b0; addr = 32'h0; bmask = 4'h0; st_data = 32'h0; rdy = 1'b0;
      model_reset();
      #12;
      total++; if (op_data !== 32'h0) begin bad++; $display("FAIL rst_op_data got=%h exp=0", op_data); end
      total++; if (ledr !== 17'h0) begin bad++; $display("FAIL rst_ledr got=%h exp=0", ledr); end
      total++; if (lcd_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", lcd_vld); end
      total++; if (hex0 !== HEX_RST || hex7 !== HEX_RST) begin
         bad++; $display("FAIL rst_hex got=%h/%h exp=%h", hex0, hex7, HEX_RST);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_ledr();
      step(1'b1, 32'h0000_7000, 4'hF, 32'h0001_FFFF, 1'b0);
      total++; if (ledr !== 17'h1FFFF) begin bad++; $display("FAIL ledr got=%h exp=1ffff", ledr); end
      step(1'b0, 32'h0000_7002, 4'h0, 32'h0, 1'b0);
      total++; if (op_data !== 32'h0001_FFFF) begin bad++; $display("FAIL ledr_rd got=%h exp=0001ffff", op_data); end
   endtask

   task automatic test_bmask();
      step(1'b1, 32'h0000_7010, 4'hF, 32'hAABB_CCDD, 1'b0);
      step(1'b1, 32'h0000_7010, 4'b0100, 32'h1122_3344, 1'b0);
      total++; if (op_data !== 32'hAABB_CCDD) begin bad++; $display("FAIL same_cycle_old got=%h exp=aabbccdd", op_data); end
      step(1'b1, 32'h0000_7010, 4'b0000, 32'hFFFF_FFFF, 1'b0);
      total++; if (op_data !== 32'hAA22_CCDD) begin bad++; $display("FAIL bmask_rd got=%h exp=aa22ccdd", op_data); end
      step(1'b0, 32'h0000_7010, 4'h0, 32'h0, 1'b0);
      total++; if (op_data !== 32'hAA22_CCDD) begin bad++; $display("FAIL mask0_rd got=%h exp=aa22ccdd", op_data); end
      total++; if (ledg !== 8'hDD) begin bad++; $display("FAIL ledg got=%h exp=dd", ledg); end
   endtask

   task automatic test_hex();
      logic [27:0] exp4;
`ifdef OP_HEX_DECODE_EN
      exp4 = {7'h30, 7'h24, 7'h79, 7'h40};
`else
      exp4 = {7'h03, 7'h02, 7'h01, 7'h00};
`endif
      step(1'b1, 32'h0000_7020, 4'hF, 32'h0302_0100, 1'b0);
      total++; if ({hex3, hex2, hex1, hex0} !== exp4) begin
         bad++; $display("FAIL hex_lo got=%h exp=%h", {hex3, hex2, hex1, hex0}, exp4);
      end
      step(1'b1, 32'h0000_7024, 4'hF, 32'h8F0A_F3C5, 1'b0);
      for (int n = 4; n < 8; n++) begin
         total++; if (hex_a[n] !== exp_hex(n)) begin
            bad++; $display("FAIL hex_hi%0d got=%h exp=%h", n, hex_a[n], exp_hex(n));
         end
      end
   endtask

   task automatic test_lcd();
      step(1'b1, 32'h0000_7030, 4'hF, 32'h1234_5678, 1'b0);
      total++; if (lcd_vld !== 1'b1 || lcd !== 32'h1234_5678) begin
         bad++; $display("FAIL lcd_first got=%b/%h exp=1/12345678", lcd_vld, lcd);
      end
      step(1'b1, 32'h0000_7030, 4'hF, 32'h9ABC_DEF0, 1'b0);
      total++; if (lcd_vld !== 1'b1 || lcd !== 32'h9ABC_DEF0) begin
         bad++; $display("FAIL lcd_overwrite got=%b/%h exp=1/9abcdef0", lcd_vld, lcd);
      end
      step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      total++; if (lcd_vld !== 1'b0) begin bad++; $display("FAIL lcd_consume got=%b exp=0", lcd_vld); end
      step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      total++; if (lcd_vld !== 1'b0) begin bad++; $display("FAIL lcd_once got=%b exp=0", lcd_vld); end
      step(1'b1, 32'h0000_7030, 4'h0, 32'hDEAD_BEEF, 1'b0);
      total++; if (lcd_vld !== 1'b0) begin bad++; $display("FAIL lcd_mask0 got=%b exp=0", lcd_vld); end
   endtask

   task automatic test_lcd_same_cycle();
      step(1'b1, 32'h0000_7030, 4'b0001, 32'h0000_0011, 1'b0);
      step(1'b1, 32'h0000_7030, 4'hF, 32'h5555_AAAA, 1'b1);
      total++; if (lcd_vld !== 1'b1 || lcd !== 32'h5555_AAAA) begin
         bad++; $display("FAIL lcd_rdy_wr got=%b/%h exp=1/5555aaaa", lcd_vld, lcd);
      end
      step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      total++; if (lcd_vld !== 1'b0) begin bad++; $display("FAIL lcd_idle_rdy got=%b exp=0", lcd_vld); end
   endtask

   task automatic test_miss();
      step(1'b1, 32'h0000_8000, 4'hF, 32'hFFFF_FFFF, 1'b0);
      step(1'b1, 32'h0000_7040, 4'hF, 32'hFFFF_FFFF, 1'b0);
      step(1'b1, 32'h0000_6FFC, 4'hF, 32'hFFFF_FFFF, 1'b0);
      step(1'b0, 32'h0000_8000, 4'h0, 32'h0, 1'b0);
      total++; if (op_data !== 32'h0) begin bad++; $display("FAIL miss_rd got=%h exp=0", op_data); end
      total++; if (ledr !== mm[0][16:0] || lcd_vld !== 1'b0) begin
         bad++; $display("FAIL miss_state got=%h/%b exp=%h/0", ledr, lcd_vld, mm[0][16:0]);
      end
      step(1'b0, 32'h0000_703C, 4'h0, 32'h0, 1'b0);
      total++; if (op_data !== mm[15]) begin bad++; $display("FAIL word15_rd got=%h exp=%h", op_data, mm[15]); end
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            a = 32'h0000_7000 + 32'($urandom_range(0, 63));
         end else begin
            a = $urandom;
            if (a[31:6] == 26'h00001C0) a = a ^ 32'h8000_0000;
         end
         step(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
         total++; if (op_data !== exp_rd) begin bad++; $display("FAIL rnd_rd i=%0d got=%h exp=%h", i, op_data, exp_rd); end
         total++; if (ledr !== mm[0][16:0] || ledg !== mm[4][7:0]) begin
            bad++; $display("FAIL rnd_led i=%0d got=%h/%h exp=%h/%h", i, ledr, ledg, mm[0][16:0], mm[4][7:0]);
         end
         total++; if (lcd !== mm[12] || lcd_vld !== pend) begin
            bad++; $display("FAIL rnd_lcd i=%0d got=%h/%b exp=%h/%b", i, lcd, lcd_vld, mm[12], pend);
         end
         for (int n = 0; n < 8; n++) begin
            total++; if (hex_a[n] !== exp_hex(n)) begin
               bad++; $display("FAIL rnd_hex%0d i=%0d got=%h exp=%h", n, i, hex_a[n], exp_hex(n));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, 32'h0000_7000, 4'hF, 32'h0000_1234, 1'b0);
      step(1'b1, 32'h0000_7030, 4'hF, 32'hCAFE_F00D, 1'b0);
      step(1'b0, 32'h0000_7030, 4'h0, 32'h0, 1'b0);
      total++; if (lcd_vld !== 1'b1) begin bad++; $display("FAIL pre_rst_vld got=%b exp=1", lcd_vld); end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      total++; if (lcd_vld !== 1'b0 || op_data !== 32'h0) begin
         bad++; $display("FAIL arst_vld_rd got=%b/%h exp=0/0", lcd_vld, op_data);
      end
      total++; if (ledr !== 17'h0 || ledg !== 8'h0 || lcd !== 32'h0) begin
         bad++; $display("FAIL arst_pins got=%h/%h/%h exp=0", ledr, ledg, lcd);
      end
      total++; if (hex0 !== HEX_RST || hex4 !== HEX_RST) begin
         bad++; $display("FAIL arst_hex got=%h/%h exp=%h", hex0, hex4, HEX_RST);
      end
      #2;
      rst_n = 1'b1;
      step(1'b0, 32'h0000_7030, 4'h0, 32'h0, 1'b0);
      total++; if (lcd_vld !== 1'b0 || op_data !== 32'h0) begin
         bad++; $display("FAIL post_rst got=%b/%h exp=0/0", lcd_vld, op_data);
      end
   endtask

   initial begin
      test_reset();
      test_ledr();
      test_bmask();
      test_hex();
      test_lcd();
      test_lcd_same_cycle();
      test_miss();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
